tick_count_decoder: RTL and testbench

Converts the free-running 64-bit centisecond tick count produced by the timer/stopwatch block into human-readable time-of-day and calendar fields. It sits between the 100 Hz tick counter and the display logic. It performs one multi-cycle decode per start request, using a serial divider followed by subtraction loops, and holds its results stable until the next request. Tick 0 is 1970-01-01 00:00:00.00 UTC.

---
 rtl/tick_decode_pkg.sv | 51 +++++
 rtl/tick_day_divider.sv | 70 +++++++
 rtl/tick_count_decoder.sv | 275 +++++++++++++++++++++++++++
 tb/tb_tick_count_decoder.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/tick_decode_pkg.sv
`default_nettype none
// ============================================================================
// Module   : tick_decode_pkg
// Purpose  : Shared constants, FSM state type and calendar helper functions
//            for the centisecond tick-count decoder.
// Revision : 1.0 - initial release
// ============================================================================
package tick_decode_pkg;

  localparam logic [23:0] TICKS_PER_DAY  = 24'd8640000;
  localparam logic [23:0] TICKS_PER_HOUR = 24'd360000;
  localparam logic [23:0] TICKS_PER_MIN  = 24'd6000;
  localparam logic [23:0] TICKS_PER_SEC  = 24'd100;
  localparam logic [13:0] EPOCH_YEAR     = 14'd1970;
  localparam logic [2:0]  EPOCH_WEEKDAY  = 3'd4;

  // Calendar values reported when the day index is past the last valid day
  localparam logic [13:0] CLAMP_YEAR     = 14'd9999;
  localparam logic [3:0]  CLAMP_MONTH    = 4'd12;
  localparam logic [4:0]  CLAMP_DATE     = 5'd31;
  localparam logic [2:0]  CLAMP_WEEKDAY  = 3'd5;

  typedef enum logic [3:0] {
    ST_IDLE    = 4'd0,
    ST_DIV_DAY = 4'd1,
    ST_SPLIT_H = 4'd2,
    ST_SPLIT_M = 4'd3,
    ST_SPLIT_S = 4'd4,
    ST_YEAR    = 4'd5,
    ST_MONTH   = 4'd6,
    ST_WDAY    = 4'd7,
    ST_DONE    = 4'd8
  } decode_state_t;

  // Gregorian leap rule: every 4th year, except centuries not divisible by 400
  function automatic logic isLeap(input logic [13:0] year);
    return (((year % 14'd4) == 14'd0) && ((year % 14'd100) != 14'd0)) ||
           ((year % 14'd400) == 14'd0);
  endfunction

  // Days in a month (1..12); February follows the leap flag
  function automatic logic [4:0] monthLength(input logic [3:0] month, input logic leap);
    case (month)
      4'd2:                      return leap ? 5'd29 : 5'd28;
      4'd4, 4'd6, 4'd9, 4'd11:   return 5'd30;
      default:                   return 5'd31;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/tick_day_divider.sv
`default_nettype none
// ============================================================================
// Module   : tick_day_divider
// Purpose  : 64-by-24-bit serial restoring divider, one quotient bit per
//            cycle. The first step runs on the start edge itself, so the
//            result is ready after 64 edges and flagged by a one-cycle done.
// Revision : 1.0 - initial release
// ============================================================================
module tick_day_divider (
  input  logic        clockSignal,
  input  logic        resetN,
  input  logic        start,
  input  logic [63:0] dividend,
  input  logic [23:0] divisor,
  output logic        done,
  output logic [63:0] quotient,
  output logic [23:0] remainder
);

  logic        r_active;
  logic [5:0]  r_count;
  logic [63:0] w_src_quot;
  logic [23:0] w_src_rem;
  logic [24:0] w_shifted;
  logic [23:0] w_diff;
  logic        w_fits;
  logic [63:0] w_next_quot;
  logic [23:0] w_next_rem;

  // One restoring step; a start request restarts from the fresh dividend
  always_comb begin
    w_src_quot  = start ? dividend : quotient;
    w_src_rem   = start ? 24'd0 : remainder;
    w_shifted   = {w_src_rem, w_src_quot[63]};
    w_fits      = (w_shifted >= {1'b0, divisor});
    // Result is below the divisor whenever it fits, so 24 bits suffice
    w_diff      = w_shifted[23:0] - divisor;
    w_next_rem  = w_fits ? w_diff : w_shifted[23:0];
    w_next_quot = {w_src_quot[62:0], w_fits};
  end

  // Iteration counter, partial remainder / quotient shift register, done pulse
  always_ff @(posedge clockSignal or negedge resetN) begin
    if (!resetN) begin
      r_active  <= 1'b0;
      r_count   <= 6'd0;
      done      <= 1'b0;
      quotient  <= 64'd0;
      remainder <= 24'd0;
    end else begin
      done <= 1'b0;
      if (start) begin
        quotient  <= w_next_quot;
        remainder <= w_next_rem;
        r_active  <= 1'b1;
        r_count   <= 6'd1;
      end else if (r_active) begin
        quotient  <= w_next_quot;
        remainder <= w_next_rem;
        r_count   <= r_count + 6'd1;
        if (r_count == 6'd63) begin
          r_active <= 1'b0;
          done     <= 1'b1;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/tick_count_decoder.sv
`default_nettype none
// ============================================================================
// Module   : tick_count_decoder
// Purpose  : Multi-cycle decode of a 64-bit centisecond tick count into
//            time-of-day, day count and (optionally) calendar fields.
//            Macro DATE_DECODE_EN enables the year/month/weekday decode;
//            without it the calendar outputs are tied to 1970-01-01 Thu.
// Revision : 1.0 - initial release
// ============================================================================
module tick_count_decoder
  import tick_decode_pkg::*;
#(
  parameter logic [31:0] MAX_DAYS = 32'd2932896
) (
  input  logic        clockSignal,
  input  logic        resetN,
  input  logic        startDecode,
  input  logic [63:0] tickCount,
  output logic        busy,
  output logic        done,
  output logic        overflow,
  output logic [6:0]  centiseconds,
  output logic [5:0]  seconds,
  output logic [5:0]  minutes,
  output logic [4:0]  hours,
  output logic [31:0] dayCount,
  output logic [13:0] yearDisplay,
  output logic [3:0]  monthDisplay,
  output logic [4:0]  dateDisplay,
  output logic [2:0]  dayDisplay
);

  decode_state_t r_state;
  decode_state_t w_next_state;

  logic        w_accept;
  logic        w_div_start;
  logic        w_div_done;
  logic [63:0] w_div_quot;
  logic [23:0] w_div_rem;

  logic [23:0] r_rem;
  logic [4:0]  r_hours;
  logic [5:0]  r_minutes;
  logic [5:0]  r_seconds;
  logic [31:0] r_daycnt;
  logic        r_ovf;

`ifdef DATE_DECODE_EN
  logic [31:0] r_days;
  logic [13:0] r_year;
  logic [3:0]  r_month;
  logic [5:0]  r_wacc;
  logic        r_wday_add;
  logic        w_leap;
  logic [31:0] w_year_len;
  logic [4:0]  w_month_len;
  logic [4:0]  w_month_mod7;
  logic [5:0]  w_wacc_year_sum;
  logic [5:0]  w_wacc_year;
  logic [5:0]  w_wacc_month_sum;
  logic [5:0]  w_wacc_month;
`endif

  // A request landing in the done cycle is dropped; it is taken one cycle later
  assign w_accept = (r_state == ST_IDLE) && startDecode && !done;
  assign busy     = (r_state != ST_IDLE);

  tick_day_divider u_day_divider (
    .clockSignal (clockSignal),
    .resetN      (resetN),
    .start       (w_div_start),
    .dividend    (tickCount),
    .divisor     (TICKS_PER_DAY),
    .done        (w_div_done),
    .quotient    (w_div_quot),
    .remainder   (w_div_rem)
  );

`ifdef DATE_DECODE_EN
  // Year/month lengths and weekday accumulator updates, kept mod 7
  always_comb begin
    w_leap           = isLeap(r_year);
    w_year_len       = w_leap ? 32'd366 : 32'd365;
    w_month_len      = monthLength(r_month, w_leap);
    w_month_mod7     = w_month_len % 5'd7;
    w_wacc_year_sum  = r_wacc + (w_leap ? 6'd2 : 6'd1);
    w_wacc_year      = (w_wacc_year_sum >= 6'd7) ? (w_wacc_year_sum - 6'd7) : w_wacc_year_sum;
    w_wacc_month_sum = r_wacc + {1'b0, w_month_mod7};
    w_wacc_month     = (w_wacc_month_sum >= 6'd7) ? (w_wacc_month_sum - 6'd7) : w_wacc_month_sum;
  end
`endif

  // FSM state register
  always_ff @(posedge clockSignal or negedge resetN) begin
    if (!resetN) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic and divider launch
  always_comb begin
    w_next_state = r_state;
    w_div_start  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_div_start  = 1'b1;
          w_next_state = ST_DIV_DAY;
        end
      end
      ST_DIV_DAY: if (w_div_done)                  w_next_state = ST_SPLIT_H;
      ST_SPLIT_H: if (r_rem < TICKS_PER_HOUR)      w_next_state = ST_SPLIT_M;
      ST_SPLIT_M: if (r_rem < TICKS_PER_MIN)       w_next_state = ST_SPLIT_S;
      ST_SPLIT_S: begin
        if (r_rem < TICKS_PER_SEC) begin
`ifdef DATE_DECODE_EN
          w_next_state = r_ovf ? ST_DONE : ST_YEAR;
`else
          w_next_state = ST_DONE;
`endif
        end
      end
`ifdef DATE_DECODE_EN
      ST_YEAR:  if (r_days < w_year_len)             w_next_state = ST_MONTH;
      ST_MONTH: if (r_days < {27'd0, w_month_len})   w_next_state = ST_WDAY;
      ST_WDAY:  if (!r_wday_add && (r_wacc < 6'd7))  w_next_state = ST_DONE;
`endif
      ST_DONE:  w_next_state = ST_IDLE;
      default:  w_next_state = ST_IDLE;
    endcase
  end

  // Time split by repeated subtraction, then commit of time/day outputs
  always_ff @(posedge clockSignal or negedge resetN) begin
    if (!resetN) begin
      r_rem        <= 24'd0;
      r_hours      <= 5'd0;
      r_minutes    <= 6'd0;
      r_seconds    <= 6'd0;
      r_daycnt     <= 32'd0;
      r_ovf        <= 1'b0;
      done         <= 1'b0;
      overflow     <= 1'b0;
      centiseconds <= 7'd0;
      seconds      <= 6'd0;
      minutes      <= 6'd0;
      hours        <= 5'd0;
      dayCount     <= 32'd0;
    end else begin
      done <= 1'b0;
      case (r_state)
        ST_DIV_DAY: begin
          if (w_div_done) begin
            r_rem     <= w_div_rem;
            r_hours   <= 5'd0;
            r_minutes <= 6'd0;
            r_seconds <= 6'd0;
            r_daycnt  <= (|w_div_quot[63:32]) ? 32'hFFFF_FFFF : w_div_quot[31:0];
`ifdef DATE_DECODE_EN
            r_ovf     <= (w_div_quot > {32'd0, MAX_DAYS});
`else
            r_ovf     <= |w_div_quot[63:32];
`endif
          end
        end
        ST_SPLIT_H: begin
          if (r_rem >= TICKS_PER_HOUR) begin
            r_rem   <= r_rem - TICKS_PER_HOUR;
            r_hours <= r_hours + 5'd1;
          end
        end
        ST_SPLIT_M: begin
          if (r_rem >= TICKS_PER_MIN) begin
            r_rem     <= r_rem - TICKS_PER_MIN;
            r_minutes <= r_minutes + 6'd1;
          end
        end
        ST_SPLIT_S: begin
          if (r_rem >= TICKS_PER_SEC) begin
            r_rem     <= r_rem - TICKS_PER_SEC;
            r_seconds <= r_seconds + 6'd1;
          end
        end
        ST_DONE: begin
          done         <= 1'b1;
          overflow     <= r_ovf;
          centiseconds <= r_rem[6:0];
          seconds      <= r_seconds;
          minutes      <= r_minutes;
          hours        <= r_hours;
          dayCount     <= r_daycnt;
        end
        default: ;
      endcase
    end
  end

`ifdef DATE_DECODE_EN
  // Calendar walk (year, month, weekday) and commit of calendar outputs
  always_ff @(posedge clockSignal or negedge resetN) begin
    if (!resetN) begin
      r_days       <= 32'd0;
      r_year       <= EPOCH_YEAR;
      r_month      <= 4'd1;
      r_wacc       <= {3'd0, EPOCH_WEEKDAY};
      r_wday_add   <= 1'b0;
      yearDisplay  <= EPOCH_YEAR;
      monthDisplay <= 4'd1;
      dateDisplay  <= 5'd1;
      dayDisplay   <= EPOCH_WEEKDAY;
    end else begin
      case (r_state)
        ST_DIV_DAY: begin
          if (w_div_done) begin
            r_days     <= w_div_quot[31:0];
            r_year     <= EPOCH_YEAR;
            r_month    <= 4'd1;
            r_wacc     <= {3'd0, EPOCH_WEEKDAY};
            r_wday_add <= 1'b0;
          end
        end
        ST_YEAR: begin
          if (r_days >= w_year_len) begin
            r_days <= r_days - w_year_len;
            r_year <= r_year + 14'd1;
            r_wacc <= w_wacc_year;
          end
        end
        ST_MONTH: begin
          if (r_days >= {27'd0, w_month_len}) begin
            r_days  <= r_days - {27'd0, w_month_len};
            r_month <= r_month + 4'd1;
            r_wacc  <= w_wacc_month;
          end else begin
            r_wday_add <= 1'b1;
          end
        end
        ST_WDAY: begin
          // Remaining days are at most 30, so the sum stays within 6 bits
          if (r_wday_add) begin
            r_wacc     <= r_wacc + r_days[5:0];
            r_wday_add <= 1'b0;
          end else if (r_wacc >= 6'd7) begin
            r_wacc <= r_wacc - 6'd7;
          end
        end
        ST_DONE: begin
          if (r_ovf) begin
            yearDisplay  <= CLAMP_YEAR;
            monthDisplay <= CLAMP_MONTH;
            dateDisplay  <= CLAMP_DATE;
            dayDisplay   <= CLAMP_WEEKDAY;
          end else begin
            yearDisplay  <= r_year;
            monthDisplay <= r_month;
            dateDisplay  <= r_days[4:0] + 5'd1;
            dayDisplay   <= r_wacc[2:0];
          end
        end
        default: ;
      endcase
    end
  end
`else
  assign yearDisplay  = EPOCH_YEAR;
  assign monthDisplay = 4'd1;
  assign dateDisplay  = 5'd1;
  assign dayDisplay   = EPOCH_WEEKDAY;
`endif

endmodule
`default_nettype wire

// File: tb/tb_tick_count_decoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_tick_count_decoder
// Purpose  : Self-checking bench for tick_count_decoder with directed corner
//            cases, randomized tick counts and a civil-calendar reference.
// Revision : 1.0 - initial release
// ============================================================================
module tb_tick_count_decoder;

  localparam longint unsigned TPD   = 64'd8640000;
  localparam longint unsigned MAXD  = 64'd2932896;
  localparam int              LIMIT = 10000;

  logic        clockSignal = 1'b0;
  logic        resetN      = 1'b0;
  logic        startDecode = 1'b0;
  logic [63:0] tickCount   = 64'd0;
  logic        busy;
  logic        done;
  logic        overflow;
  logic [6:0]  centiseconds;
  logic [5:0]  seconds;
  logic [5:0]  minutes;
  logic [4:0]  hours;
  logic [31:0] dayCount;
  logic [13:0] yearDisplay;
  logic [3:0]  monthDisplay;
  logic [4:0]  dateDisplay;
  logic [2:0]  dayDisplay;

  int n_compared   = 0;
  int n_mismatched = 0;
  int done_pulses  = 0;

  tick_count_decoder #(.MAX_DAYS(32'd2932896)) dut (
    .clockSignal  (clockSignal),
    .resetN       (resetN),
    .startDecode  (startDecode),
    .tickCount    (tickCount),
    .busy         (busy),
    .done         (done),
    .overflow     (overflow),
    .centiseconds (centiseconds),
    .seconds      (seconds),
    .minutes      (minutes),
    .hours        (hours),
    .dayCount     (dayCount),
    .yearDisplay  (yearDisplay),
    .monthDisplay (monthDisplay),
    .dateDisplay  (dateDisplay),
    .dayDisplay   (dayDisplay)
  );

  always #5 clockSignal = ~clockSignal;

  always @(negedge clockSignal) if (done) done_pulses++;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_compared++;
    if (obs !== exp) begin
      n_mismatched++;
      $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic longint unsigned pack4(input longint unsigned a, input longint unsigned b,
                                            input longint unsigned c, input longint unsigned d);
    return (a << 48) | (b << 32) | (c << 16) | d;
  endfunction

  // Reference: plain division for time, days-to-civil-date conversion for calendar
  task automatic model(input logic [63:0] ticks, output logic [63:0] e_time,
                       output logic [63:0] e_dc, output logic [63:0] e_ovf,
                       output logic [63:0] e_cal);
    longint unsigned days, rem;
    days   = ticks / TPD;
    rem    = ticks % TPD;
    e_time = pack4(rem / 360000, (rem % 360000) / 6000, (rem % 6000) / 100, rem % 100);
    e_dc   = (days > 64'hFFFF_FFFF) ? 64'hFFFF_FFFF : days;
`ifdef DATE_DECODE_EN
    if (days > MAXD) begin
      e_ovf = 1;
      e_cal = pack4(9999, 12, 31, 5);
    end else begin
      longint z, era, doe, yoe, doy, mp, d, m, y;
      z   = longint'(days) + 719468;
      era = z / 146097;
      doe = z - era * 146097;
      yoe = (doe - doe / 1460 + doe / 36524 - doe / 146096) / 365;
      doy = doe - (365 * yoe + yoe / 4 - yoe / 100);
      mp  = (5 * doy + 2) / 153;
      d   = doy - (153 * mp + 2) / 5 + 1;
      m   = (mp < 10) ? mp + 3 : mp - 9;
      y   = yoe + era * 400 + ((m <= 2) ? 1 : 0);
      e_ovf = 0;
      e_cal = pack4(y, m, d, (days + 4) % 7);
    end
`else
    e_ovf = (days > 64'hFFFF_FFFF) ? 1 : 0;
    e_cal = pack4(1970, 1, 1, 4);
`endif
  endtask

  task automatic issue(input logic [63:0] ticks, input string tag);
    startDecode = 1'b1;
    tickCount   = ticks;
    @(negedge clockSignal);
    startDecode = 1'b0;
    chk({tag, ":busy_after_accept"}, busy, 1);
  endtask

  // Waits for done (bounded) and compares all fields; returns on the done cycle
  task automatic finish(input logic [63:0] ticks, input string tag);
    logic [63:0] e_time, e_dc, e_ovf, e_cal;
    int cyc;
    cyc = 0;
    while (!done && cyc < LIMIT) begin
      @(negedge clockSignal);
      cyc++;
    end
    chk({tag, ":done_seen"}, done, 1);
    if (!done) return;
    model(ticks, e_time, e_dc, e_ovf, e_cal);
    chk({tag, ":busy_at_done"}, busy, 0);
    chk({tag, ":time"}, pack4(hours, minutes, seconds, centiseconds), e_time);
    chk({tag, ":dayCount"}, dayCount, e_dc);
    chk({tag, ":overflow"}, overflow, e_ovf);
    chk({tag, ":calendar"}, pack4(yearDisplay, monthDisplay, dateDisplay, dayDisplay), e_cal);
  endtask

  task automatic run_decode(input logic [63:0] ticks, input string tag);
    issue(ticks, tag);
    finish(ticks, tag);
    @(negedge clockSignal);
    chk({tag, ":done_one_cycle"}, done, 0);
  endtask

  task automatic chk_reset_values(input string tag);
    chk({tag, ":busy"}, busy, 0);
    chk({tag, ":done"}, done, 0);
    chk({tag, ":overflow"}, overflow, 0);
    chk({tag, ":time"}, pack4(hours, minutes, seconds, centiseconds), 0);
    chk({tag, ":dayCount"}, dayCount, 0);
    chk({tag, ":calendar"}, pack4(yearDisplay, monthDisplay, dateDisplay, dayDisplay),
        pack4(1970, 1, 1, 4));
  endtask

  initial begin
    logic [63:0] t;
    int rst_at;

    resetN = 1'b0;
    repeat (3) @(negedge clockSignal);
    chk_reset_values("reset");
    resetN = 1'b1;
    @(negedge clockSignal);

    run_decode(64'd0, "epoch");
    run_decode(64'd8639999, "end_of_day0");
    run_decode(64'd95178240000, "leap2000");
    run_decode(64'd214748364800, "y2038");
    run_decode(MAXD * TPD + 64'd123456, "last_valid_day");
    run_decode((MAXD + 1) * TPD, "first_overflow_day");
    run_decode(64'hFFFF_FFFF_FFFF_FFFF, "saturate");

    // Request in the done cycle is dropped; held one more cycle it is taken
    issue(64'd31536000 * 100, "b2b_a");
    finish(64'd31536000 * 100, "b2b_a");
    startDecode = 1'b1;
    tickCount   = 64'd86399999 + 64'd5 * TPD;
    @(negedge clockSignal);
    chk("b2b:ignored_in_done_cycle", busy, 0);
    @(negedge clockSignal);
    startDecode = 1'b0;
    chk("b2b:accepted_next_cycle", busy, 1);
    finish(64'd86399999 + 64'd5 * TPD, "b2b_b");
    @(negedge clockSignal);

    for (int i = 0; i < 16; i++) begin
      t = longint'($urandom_range(0, 80000)) * TPD + longint'($urandom_range(0, 8639999));
      run_decode(t, $sformatf("rand%0d", i));
    end
    t = {$urandom | 32'h0100_0000, $urandom};
    run_decode(t, "rand_huge");

    // Second request while busy, then reset mid-calendar (mid-divide without it)
`ifdef DATE_DECODE_EN
    rst_at = 70;
`else
    rst_at = 30;
`endif
    done_pulses = 0;
    issue(64'd20000 * TPD, "abort");
    repeat (5) @(negedge clockSignal);
    startDecode = 1'b1;
    tickCount   = 64'd0;
    @(negedge clockSignal);
    startDecode = 1'b0;
    repeat (rst_at) @(negedge clockSignal);
    chk("abort:busy_before_reset", busy, 1);
    chk("abort:no_done_before_reset", done_pulses, 0);
    resetN = 1'b0;
    #2;
    chk("abort:busy_cleared_async", busy, 0);
    @(negedge clockSignal);
    chk_reset_values("abort_reset");
    @(negedge clockSignal);
    resetN = 1'b1;
    repeat (200) @(negedge clockSignal);
    chk("abort:no_done_after_reset", done_pulses, 0);
    chk("abort:idle_after_reset", busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
`default_nettype wire
